// File: rtl/tb_gpio_pkg.sv
// tb_gpio_pkg: shared encodings and constants for the GPIO pad agent.
// Holds pin modes, pulse FSM states, LFSR taps/seed and the LFSR step.
package tb_gpio_pkg;

  typedef enum logic [1:0] {
    TB_GPIO_CONST    = 2'd0,
    TB_GPIO_RANDOM   = 2'd1,
    TB_GPIO_LOOPBACK = 2'd2,
    TB_GPIO_PULSE    = 2'd3
  } tb_gpio_mode_e;

  typedef enum logic {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } tb_gpio_pulse_e;

  localparam logic [31:0] TB_GPIO_TAPS = 32'h8020_0003;
  localparam logic [31:0] TB_GPIO_SEED = 32'h1ACE_B00C;

  function automatic logic [31:0] tb_gpio_lfsr_next(
    input logic [31:0] s
  );
    return {1'b0, s[31:1]} ^ (s[0] ? TB_GPIO_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/tb_gpio_lfsr.sv
// tb_gpio_lfsr: 32-bit right-shifting Galois LFSR.
// Loads SEED on reset and steps once per clock afterwards.
module tb_gpio_lfsr
  import tb_gpio_pkg::*;
#(
  parameter logic [31:0] SEED = TB_GPIO_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] state
);

  // free-running sequence from the seed
  always_ff @(posedge clk) begin
    if (rst) state <= SEED;
    else     state <= tb_gpio_lfsr_next(state);
  end

endmodule

// File: rtl/tb_gpio_agent.sv
// tb_gpio_agent: runtime-configurable GPIO pad agent (drive, monitor, contention).
// Define TB_GPIO_RANDOM_EN to build the LFSR and the RANDOM pin mode.
module tb_gpio_agent
  import tb_gpio_pkg::*;
#(
  parameter int          NUM_PINS  = 32,
  parameter int          HOLD_W    = 16,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = TB_GPIO_SEED,
  localparam int         SEL_W     = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_pin,
  input  logic [1:0]          cfg_mode,
  input  logic                cfg_val,
  input  logic [HOLD_W-1:0]   cfg_hold,
  input  logic [NUM_PINS-1:0] pad_oval,
  input  logic [NUM_PINS-1:0] pad_oe,
  output logic [NUM_PINS-1:0] pad_ival,
  input  logic [SEL_W-1:0]    cnt_sel,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    edge_cnt,
  output logic [NUM_PINS-1:0] pulse_busy,
  output logic                contention,
  output logic [SEL_W-1:0]    contention_pin
);

  logic [31:0]         lfsr;
  tb_gpio_mode_e       wmode;
  logic [NUM_PINS-1:0] cont_raw;
  logic [CNT_W-1:0]    cnt [NUM_PINS];
  logic [SEL_W-1:0]    first_pin;

`ifdef TB_GPIO_RANDOM_EN
  tb_gpio_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .state (lfsr)
  );
`else
  // no generator: RANDOM is never stored, so this is never selected
  assign lfsr = LFSR_SEED;
`endif

  // mode actually stored on a write
  always_comb begin
    wmode = tb_gpio_mode_e'(cfg_mode);
`ifndef TB_GPIO_RANDOM_EN
    if (wmode == TB_GPIO_RANDOM) wmode = TB_GPIO_CONST;
`endif
  end

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    tb_gpio_mode_e  mode_q;
    tb_gpio_pulse_e st_q, st_d;
    logic              val_q, ival_q, busy_q;
    logic              ival_d, busy_d, wr, lvl, lvl_q;
    logic [HOLD_W-1:0] hold_q, ctr_q, ctr_d;
    logic [CNT_W-1:0]  cnt_q;

    assign wr  = cfg_we && (cfg_pin == SEL_W'(i));
    assign lvl = pad_oe[i] & pad_oval[i];

    // pulse state register
    always_ff @(posedge sys_clk) begin
      if (sys_rst) st_q <= PS_IDLE;
      else         st_q <= st_d;
    end

    // pulse next state: a write always re-evaluates
    always_comb begin
      st_d = st_q;
      if (wr)
        st_d = (wmode == TB_GPIO_PULSE && cfg_hold != '0)
             ? PS_ACTIVE : PS_IDLE;
      else if (st_q == PS_ACTIVE && ctr_q == HOLD_W'(1))
        st_d = PS_IDLE;
    end

    // next pad value, busy flag and counter
    always_comb begin
      ival_d = val_q;
      busy_d = 1'b0;
      ctr_d  = ctr_q;
      if (st_q == PS_ACTIVE) begin
        ival_d = ~val_q;
        busy_d = 1'b1;
        ctr_d  = ctr_q - HOLD_W'(1);
      end else begin
        unique case (mode_q)
          TB_GPIO_RANDOM: begin
            if (ctr_q != '0) begin
              ctr_d = ctr_q - HOLD_W'(1);
              ival_d = ival_q;
            end else begin
              ival_d = lfsr[i % 32];
              ctr_d  = hold_q;
            end
          end
          TB_GPIO_LOOPBACK: ival_d = pad_oe[i] ? pad_oval[i] : val_q;
          default: ival_d = val_q;
        endcase
      end
      if (wr) ctr_d = cfg_hold;
    end

    // pin config and driven pad state
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        mode_q <= TB_GPIO_CONST;
        val_q  <= 1'b1;
        hold_q <= '0;
        ctr_q  <= '0;
        ival_q <= 1'b1;
        busy_q <= 1'b0;
      end else begin
        ctr_q  <= ctr_d;
        ival_q <= ival_d;
        busy_q <= busy_d;
        if (wr) begin
          mode_q <= wmode;
          val_q  <= cfg_val;
          hold_q <= cfg_hold;
        end
      end
    end

    // saturating rise counter; clear wins over an edge
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        lvl_q <= lvl;
        if (cnt_clr && cnt_sel == SEL_W'(i))
          cnt_q <= '0;
        else if (lvl && !lvl_q && cnt_q != '1)
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign pad_ival[i]   = ival_q;
    assign pulse_busy[i] = busy_q;
    assign cnt[i]        = cnt_q;
    assign cont_raw[i]   = (mode_q != TB_GPIO_LOOPBACK) & pad_oe[i]
                         & (pad_oval[i] != ival_q);
  end

  // readout mux
  always_comb begin
    edge_cnt = '0;
    for (int k = 0; k < NUM_PINS; k++)
      if (cnt_sel == SEL_W'(k)) edge_cnt = cnt[k];
  end

  // lowest contending pin
  always_comb begin
    first_pin = '0;
    for (int k = NUM_PINS - 1; k >= 0; k--)
      if (cont_raw[k]) first_pin = SEL_W'(k);
  end

  // sticky flag; pin captured only on the first event
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      contention     <= 1'b0;
      contention_pin <= '0;
    end else if (!contention && |cont_raw) begin
      contention     <= 1'b1;
      contention_pin <= first_pin;
    end
  end

endmodule

// File: tb/tb_tb_gpio_agent.sv
// tb_tb_gpio_agent: self-checking bench for tb_gpio_agent.
// Directed table, hand sequences and random stimulus against a time-based model.
module tb_tb_gpio_agent;

  localparam int NP   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          cfg_we;
  logic [4:0]    cfg_pin;
  logic [1:0]    cfg_mode;
  logic          cfg_val;
  logic [15:0]   cfg_hold;
  logic [NP-1:0] pad_oval;
  logic [NP-1:0] pad_oe;
  logic [NP-1:0] pad_ival;
  logic [4:0]    cnt_sel;
  logic          cnt_clr;
  logic [CW-1:0] edge_cnt;
  logic [NP-1:0] pulse_busy;
  logic          contention;
  logic [4:0]    contention_pin;

  int vectors = 0;
  int fails   = 0;

  tb_gpio_agent #(
    .NUM_PINS  (NP),
    .HOLD_W    (16),
    .CNT_W     (CW),
    .LFSR_SEED (SEED)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .cfg_we         (cfg_we),
    .cfg_pin        (cfg_pin),
    .cfg_mode       (cfg_mode),
    .cfg_val        (cfg_val),
    .cfg_hold       (cfg_hold),
    .pad_oval       (pad_oval),
    .pad_oe         (pad_oe),
    .pad_ival       (pad_ival),
    .cnt_sel        (cnt_sel),
    .cnt_clr        (cnt_clr),
    .edge_cnt       (edge_cnt),
    .pulse_busy     (pulse_busy),
    .contention     (contention),
    .contention_pin (contention_pin)
  );

  always #5 sys_clk = ~sys_clk;

  // reference model: per-pin config plus the edge index of its last write
  int          e;
  logic [1:0]  m_mode [NP];
  logic        m_val  [NP];
  int          m_hold [NP];
  int          m_w    [NP];
  int          x_cnt  [NP];
  logic [NP-1:0] x_ival, x_busy, x_prev;
  logic        x_cont;
  int          x_cpin;
  logic [31:0] x_lfsr;

  function automatic void m_reset();
    e = 0;
    for (int i = 0; i < NP; i++) begin
      m_mode[i] = 2'd0; m_val[i] = 1'b1;
      m_hold[i] = 0;    m_w[i]   = 0;
      x_cnt[i]  = 0;
    end
    x_ival = '1; x_busy = '0; x_prev = '0;
    x_cont = 1'b0; x_cpin = 0;
    x_lfsr = SEED;
  endfunction

  function automatic void model_edge();
    logic [NP-1:0] ni, nb;
    logic lvl;
    int d;
    logic [1:0] wm;
    if (sys_rst) begin
      m_reset();
      return;
    end
    e++;
    if (!x_cont)
      for (int i = 0; i < NP; i++)
        if (!x_cont && m_mode[i] != 2'd2 && pad_oe[i]
            && pad_oval[i] != x_ival[i]) begin
          x_cont = 1'b1;
          x_cpin = i;
        end
    for (int i = 0; i < NP; i++) begin
      lvl = pad_oe[i] & pad_oval[i];
      if (cnt_clr && int'(cnt_sel) == i) x_cnt[i] = 0;
      else if (lvl && !x_prev[i] && x_cnt[i] < CMAX) x_cnt[i]++;
      x_prev[i] = lvl;
    end
    for (int i = 0; i < NP; i++) begin
      d = e - m_w[i];
      ni[i] = m_val[i];
      nb[i] = 1'b0;
      case (m_mode[i])
        2'd1: ni[i] = (d > 0 && d % (m_hold[i] + 1) == 0)
                    ? x_lfsr[i % 32] : x_ival[i];
        2'd2: ni[i] = pad_oe[i] ? pad_oval[i] : m_val[i];
        2'd3: if (m_hold[i] != 0 && d >= 1 && d <= m_hold[i]) begin
                ni[i] = ~m_val[i];
                nb[i] = 1'b1;
              end
        default: ;
      endcase
    end
    x_ival = ni;
    x_busy = nb;
    x_lfsr = (x_lfsr >> 1) ^ (x_lfsr[0] ? 32'h8020_0003 : 32'h0);
    if (cfg_we) begin
      wm = cfg_mode;
`ifndef TB_GPIO_RANDOM_EN
      if (wm == 2'd1) wm = 2'd0;
`endif
      m_mode[cfg_pin] = wm;
      m_val[cfg_pin]  = cfg_val;
      m_hold[cfg_pin] = int'(cfg_hold);
      m_w[cfg_pin]    = e;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("pad_ival", pad_ival, x_ival);
    chk("pulse_busy", pulse_busy, x_busy);
    chk("contention", 32'(contention), 32'(x_cont));
    chk("contention_pin", 32'(contention_pin), 32'(x_cpin));
    chk("edge_cnt", 32'(edge_cnt), 32'(x_cnt[cnt_sel]));
  endtask

  task automatic wr(input int pin, input logic [1:0] mode,
                    input logic val, input int hold);
    cfg_we = 1'b1; cfg_pin = 5'(pin); cfg_mode = mode;
    cfg_val = val; cfg_hold = 16'(hold);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  typedef struct {
    logic        we;
    int          pin;
    logic [1:0]  mode;
    logic        val;
    int          hold;
    logic [31:0] ival;
    logic [31:0] busy;
  } vec_t;

  function automatic vec_t mk(logic we, int pin, logic [1:0] mode,
                              logic val, int hold,
                              logic [31:0] ival, logic [31:0] busy);
    vec_t v;
    v.we = we; v.pin = pin; v.mode = mode; v.val = val;
    v.hold = hold; v.ival = ival; v.busy = busy;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    tbl[0]  = mk(1, 5, 2'd0, 0, 0, 32'hFFFF_FFFF, 32'h0);
    tbl[1]  = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFDF, 32'h0);
    tbl[2]  = mk(1, 3, 2'd3, 1, 4, 32'hFFFF_FFDF, 32'h0);
    tbl[3]  = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFD7, 32'h8);
    tbl[4]  = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFD7, 32'h8);
    tbl[5]  = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFD7, 32'h8);
    tbl[6]  = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFD7, 32'h8);
    tbl[7]  = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFDF, 32'h0);
    tbl[8]  = mk(1, 3, 2'd3, 1, 4, 32'hFFFF_FFDF, 32'h0);
    tbl[9]  = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFD7, 32'h8);
    tbl[10] = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFD7, 32'h8);
    tbl[11] = mk(1, 3, 2'd0, 1, 0, 32'hFFFF_FFD7, 32'h8);
    tbl[12] = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFDF, 32'h0);
    tbl[13] = mk(1, 3, 2'd3, 1, 0, 32'hFFFF_FFDF, 32'h0);
    tbl[14] = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFDF, 32'h0);
    tbl[15] = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFDF, 32'h0);

    sys_rst = 1'b1; cfg_we = 1'b0; cfg_pin = '0; cfg_mode = '0;
    cfg_val = 1'b0; cfg_hold = '0; pad_oval = '0; pad_oe = '0;
    cnt_sel = 5'd7; cnt_clr = 1'b0;
    m_reset();

    // reset state
    do_reset();
    chk("rst_ival", pad_ival, 32'hFFFF_FFFF);
    chk("rst_cnt", 32'(edge_cnt), 32'h0);
    chk("rst_cont", 32'(contention), 32'h0);
    step();

    // CONST and PULSE table
    for (int r = 0; r < 16; r++) begin
      cfg_we = tbl[r].we; cfg_pin = 5'(tbl[r].pin);
      cfg_mode = tbl[r].mode; cfg_val = tbl[r].val;
      cfg_hold = 16'(tbl[r].hold);
      step();
      chk("tbl_ival", pad_ival, tbl[r].ival);
      chk("tbl_busy", pulse_busy, tbl[r].busy);
    end
    cfg_we = 1'b0;

    // loopback on pin 7 with edge counting
    wr(7, 2'd2, 1, 0);
    pad_oe[7] = 1'b1; pad_oval[7] = 1'b0;
    step();
    chk("lb_start", 32'(pad_ival[7]), 32'h0);
    for (int k = 0; k < 10; k++) begin
      pad_oval[7] = ~pad_oval[7];
      step();
      chk("lb_follow", 32'(pad_ival[7]), 32'((k % 2) == 0));
    end
    chk("lb_edges", 32'(edge_cnt), 32'd5);
    pad_oe[7] = 1'b0;
    step();
    chk("lb_pull", 32'(pad_ival[7]), 32'h1);

    // contention on 2 and 9 together, then pin 0 later
    wr(2, 2'd0, 1, 0);
    wr(9, 2'd0, 1, 0);
    pad_oe[2] = 1'b1; pad_oe[9] = 1'b1;
    pad_oval[2] = 1'b0; pad_oval[9] = 1'b0;
    step();
    chk("cont_flag", 32'(contention), 32'h1);
    chk("cont_pin", 32'(contention_pin), 32'd2);
    pad_oe = '0;
    pad_oe[0] = 1'b1; pad_oval[0] = 1'b0;
    step();
    step();
    chk("cont_keep", 32'(contention_pin), 32'd2);
    chk("cont_sticky", 32'(contention), 32'h1);
    pad_oe = '0; pad_oval = '0;

    // RANDOM on pin 0, hold 3
    do_reset();
    chk("rst_cont_clr", 32'(contention), 32'h0);
    wr(0, 2'd1, 0, 3);
    for (int k = 0; k < 16; k++) begin
      step();
`ifndef TB_GPIO_RANDOM_EN
      chk("rand_off", 32'(pad_ival[0]), 32'h0);
`endif
    end

    // counter saturation and clear racing an edge
    wr(7, 2'd2, 1, 0);
    pad_oe[7] = 1'b1; pad_oval[7] = 1'b0; cnt_sel = 5'd7;
    for (int k = 0; k < 40; k++) begin
      pad_oval[7] = ~pad_oval[7];
      step();
    end
    chk("cnt_sat", 32'(edge_cnt), 32'(CMAX));
    pad_oval[7] = 1'b1; cnt_clr = 1'b1;
    step();
    chk("cnt_clr_edge", 32'(edge_cnt), 32'h0);
    cnt_clr = 1'b0; pad_oval[7] = 1'b0;
    step();
    pad_oval[7] = 1'b1;
    step();
    chk("cnt_after_clr", 32'(edge_cnt), 32'h1);
    pad_oe = '0; pad_oval = '0;

    // reset in the middle of a pulse
    wr(3, 2'd3, 1, 10);
    step(); step(); step();
    chk("mid_pulse", 32'(pulse_busy[3]), 32'h1);
    do_reset();
    chk("rst_mid_ival", pad_ival, 32'hFFFF_FFFF);
    chk("rst_mid_busy", pulse_busy, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_resume", pulse_busy, 32'h0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      sys_rst  = ($urandom_range(0, 149) == 0);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_pin  = 5'($urandom_range(0, NP - 1));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_val  = 1'($urandom_range(0, 1));
      cfg_hold = 16'($urandom_range(0, 5));
      pad_oe   = $urandom() & $urandom() & $urandom() & $urandom();
      pad_oval = $urandom();
      cnt_sel  = 5'($urandom_range(0, NP - 1));
      cnt_clr  = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
